// File: rtl/prueba_1_ascensor.sv
// prueba_1_ascensor: self-running 4-floor elevator demo.
// A clock divider produces clk_nuevo and a one-cycle tick on each of its
// rising edges. A two-state FSM (OPEN/MOVE), advancing only on tick, shuttles
// the car 0->3->0 forever and opens the doors at stop floors.
// Optional feature macro: ASC_STOP_ALL_EN (floors 1 and 2 become stop floors).
// The FSM state is visible through state_andando (1 = MOVE).
module prueba_1_ascensor #(
  parameter int CLK_DIV      = 2,
  parameter int DOOR_TICKS   = 2,
  parameter int TRAVEL_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] piso,
  output logic [1:0] direccion,
  output logic       puertas_abiertas,
  output logic       state_andando,
  output logic       clk_nuevo
);

  localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAXT = (DOOR_TICKS > TRAVEL_TICKS) ? DOOR_TICKS : TRAVEL_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] CNT_LAST    = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic { ST_OPEN = 1'b0, ST_MOVE = 1'b1 } state_t;
  typedef enum logic { HD_UP = 1'b0, HD_DOWN = 1'b1 } heading_t;

  logic [CW-1:0] r_cnt;
  logic          r_clk_nuevo;
  state_t        r_state;
  heading_t      r_heading;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_piso;
  logic [1:0]    r_direccion;
  logic          r_puertas;
  logic          r_andando;

  logic          w_div_wrap;
  logic          w_tick;
  logic [1:0]    w_next_piso;
  heading_t      w_next_heading;
  logic          w_stop_floor;

  assign w_div_wrap = (r_cnt == CNT_LAST);
  // Tick is the clk edge on which clk_nuevo rises.
  assign w_tick     = w_div_wrap && !r_clk_nuevo;

  assign w_next_piso = (r_heading == HD_UP) ? (r_piso + 2'd1) : (r_piso - 2'd1);

  // Heading flips only at the ends of the shaft, so piso never wraps.
  assign w_next_heading = (w_next_piso == 2'd3) ? HD_DOWN :
                          (w_next_piso == 2'd0) ? HD_UP   : r_heading;

`ifdef ASC_STOP_ALL_EN
  assign w_stop_floor = 1'b1;
`else
  assign w_stop_floor = (w_next_piso == 2'd0) || (w_next_piso == 2'd3);
`endif

  // Divider: counts 0..CLK_DIV-1 and toggles clk_nuevo on every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_clk_nuevo <= 1'b0;
    end else if (w_div_wrap) begin
      r_cnt       <= '0;
      r_clk_nuevo <= ~r_clk_nuevo;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Elevator FSM with registered outputs; advances only on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OPEN;
      r_heading   <= HD_UP;
      r_timer     <= '0;
      r_piso      <= 2'd0;
      r_direccion <= DIR_STOP;
      r_puertas   <= 1'b1;
      r_andando   <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        ST_OPEN: begin
          if (r_timer < DOOR_LAST) begin
            r_timer <= r_timer + TW'(1);
          end else begin
            r_timer     <= '0;
            r_state     <= ST_MOVE;
            r_puertas   <= 1'b0;
            r_andando   <= 1'b1;
            r_direccion <= (r_heading == HD_UP) ? DIR_UP : DIR_DOWN;
          end
        end
        ST_MOVE: begin
          if (r_timer < TRAVEL_LAST) begin
            r_timer <= r_timer + TW'(1);
          end else begin
            r_timer   <= '0;
            r_piso    <= w_next_piso;
            r_heading <= w_next_heading;
            if (w_stop_floor) begin
              r_state     <= ST_OPEN;
              r_puertas   <= 1'b1;
              r_andando   <= 1'b0;
              r_direccion <= DIR_STOP;
            end else begin
              r_direccion <= (w_next_heading == HD_UP) ? DIR_UP : DIR_DOWN;
            end
          end
        end
      endcase
    end
  end

  assign piso             = r_piso;
  assign direccion        = r_direccion;
  assign puertas_abiertas = r_puertas;
  assign state_andando    = r_andando;
  assign clk_nuevo        = r_clk_nuevo;

endmodule

// File: tb/tb_prueba_1_ascensor.sv
// Bench for prueba_1_ascensor: random-length runs separated by asynchronous
// resets at random points, compared against a per-tick schedule of the route.
module tb_prueba_1_ascensor;

  localparam int CLK_DIV      = 2;
  localparam int DOOR_TICKS   = 2;
  localparam int TRAVEL_TICKS = 2;
  localparam int N_SEGMENTS   = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] piso;
  logic [1:0] direccion;
  logic       puertas_abiertas;
  logic       state_andando;
  logic       clk_nuevo;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs after k ticks: {piso[1:0], direccion[1:0], doors, moving}
  logic [5:0] exp_q[$];

  prueba_1_ascensor #(
    .CLK_DIV     (CLK_DIV),
    .DOOR_TICKS  (DOOR_TICKS),
    .TRAVEL_TICKS(TRAVEL_TICKS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .piso            (piso),
    .direccion       (direccion),
    .puertas_abiertas(puertas_abiertas),
    .state_andando   (state_andando),
    .clk_nuevo       (clk_nuevo)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Route model: walk floors 0..3..0, dwelling DOOR_TICKS at stops and
  // TRAVEL_TICKS per floor step.
  task automatic build_schedule(input int n_entries);
    int  f;
    bit  up;
    bit  stop;
    bit  stop_all;
`ifdef ASC_STOP_ALL_EN
    stop_all = 1'b1;
`else
    stop_all = 1'b0;
`endif
    f  = 0;
    up = 1'b1;
    exp_q.delete();
    while (exp_q.size() < n_entries) begin
      stop = stop_all || (f == 0) || (f == 3);
      if (stop)
        for (int i = 0; i < DOOR_TICKS; i++) exp_q.push_back({f[1:0], 2'b00, 1'b1, 1'b0});
      for (int i = 0; i < TRAVEL_TICKS; i++)
        exp_q.push_back({f[1:0], (up ? 2'b01 : 2'b10), 1'b0, 1'b1});
      f = up ? f + 1 : f - 1;
      if (f == 3) up = 1'b0;
      if (f == 0) up = 1'b1;
    end
  endtask

  // Compare all outputs after edge n of the current run.
  task automatic check_snapshot(input int n, inout int prev_piso);
    int         ticks;
    logic [5:0] e;
    int         step;
    ticks = (n + CLK_DIV) / (2 * CLK_DIV);
    e     = exp_q[ticks];
    check("clk_nuevo", clk_nuevo, (n / CLK_DIV) % 2);
    check("piso", piso, e[5:4]);
    check("direccion", direccion, e[3:2]);
    check("puertas", puertas_abiertas, e[1]);
    check("andando", state_andando, e[0]);
    check("inv_doors_moving", puertas_abiertas & state_andando, 0);
    check("inv_dir_iff_moving", (direccion != 2'b00), state_andando);
    check("inv_dir_11", (direccion == 2'b11), 0);
    step = int'(piso) - prev_piso;
    check("inv_piso_step", (step >= -1 && step <= 1), 1);
    prev_piso = int'(piso);
  endtask

  task automatic run_segment(input int len);
    int prev_piso;
    prev_piso = 0;
    check_snapshot(0, prev_piso);
    for (int n = 1; n <= len; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_snapshot(n, prev_piso);
    end
  endtask

  // Assert reset between clock edges and check it acts immediately.
  task automatic async_reset_and_release();
    @(posedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check("rst_piso", piso, 0);
    check("rst_direccion", direccion, 0);
    check("rst_puertas", puertas_abiertas, 1);
    check("rst_andando", state_andando, 0);
    check("rst_clk_nuevo", clk_nuevo, 0);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    build_schedule(400);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // First run long enough for more than two round trips.
    run_segment(300);
    for (int s = 1; s < N_SEGMENTS; s++) begin
      async_reset_and_release();
      run_segment($urandom_range(10, 200));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
